wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_arbiter_if.sv | 50 +++++
 rtl/wb_scoreboard.sv | 49 ++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter slice.
// Register widths, request bundle, grant encoding.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  // One-hot register mask; x0 never maps to a bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(
    input logic [REG_ADDR_W-1:0] rd
  );
    reg_mask     = '0;
    reg_mask[rd] = (rd != '0);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU/LSU requests, RF write port,
// issue tracking and hazard lookup.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic                  alu_valid_i;
  logic [REG_ADDR_W-1:0] alu_rd_i;
  logic [XLEN-1:0]       alu_data_i;
  logic                  alu_ready_o;

  logic                  lsu_valid_i;
  logic [REG_ADDR_W-1:0] lsu_rd_i;
  logic [XLEN-1:0]       lsu_data_i;
  logic                  lsu_ready_o;

  logic                  rf_wr_en_o;
  logic [REG_ADDR_W-1:0] rf_rd_o;
  logic [XLEN-1:0]       rf_wr_data_o;

  logic                  issue_set_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic                  hazard_o;
  logic                  flush_i;
  logic [NUM_REGS-1:0]   busy_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    input  alu_ready_o,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  lsu_ready_o,
    input  rf_wr_en_o, rf_rd_o, rf_wr_data_o,
    output issue_set_i, issue_rd_i,
    output rs1_i, rs2_i, flush_i,
    input  hazard_o, busy_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    output alu_ready_o,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output lsu_ready_o,
    output rf_wr_en_o, rf_rd_o, rf_wr_data_o,
    input  issue_set_i, issue_rd_i,
    input  rs1_i, rs2_i, flush_i,
    output hazard_o, busy_o
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap: set on issue, clear on commit,
// wiped by flush; combinational hazard lookup.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  assign w_set_mask = set_i ? reg_mask(set_rd_i) : '0;
  assign w_clr_mask = clr_i ? reg_mask(clr_rd_i) : '0;

  // Next bitmap: clear first so a same-edge set wins;
  // flush overrides everything.
  always_comb begin
    w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    if (flush_i) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_o   = r_busy;
  assign hazard_o = r_busy[rs1_i] | r_busy[rs2_i];

endmodule

// File: rtl/wb_arbiter.sv
// Two-source write-back arbiter with registered RF port.
// WB_ARB_ROUND_ROBIN_EN: alternate ties, else LSU wins.
module wb_arbiter
  import wb_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  wb_arbiter_if.slave bus
);

  wb_req_t w_alu_req;
  wb_req_t w_lsu_req;
  wb_req_t w_sel_req;

  logic w_alu_gnt;
  logic w_lsu_gnt;
  logic w_tie_alu;
  logic w_xfer;
  logic w_commit;

  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;

  assign w_alu_req = '{rd: bus.alu_rd_i,
                       data: bus.alu_data_i};
  assign w_lsu_req = '{rd: bus.lsu_rd_i,
                       data: bus.lsu_data_i};

`ifdef WB_ARB_ROUND_ROBIN_EN
  grant_e r_last_grant;

  assign w_tie_alu = (r_last_grant == GNT_LSU);

  // Remember who won the most recent transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= GNT_LSU;
    end else if (w_xfer) begin
      r_last_grant <= w_alu_gnt ? GNT_ALU : GNT_LSU;
    end
  end
`else
  assign w_tie_alu = 1'b0;
`endif

  // Grant decode; a lone requester always wins.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    unique case ({bus.alu_valid_i, bus.lsu_valid_i})
      2'b10:   w_alu_gnt = 1'b1;
      2'b01:   w_lsu_gnt = 1'b1;
      2'b11: begin
        w_alu_gnt = w_tie_alu;
        w_lsu_gnt = ~w_tie_alu;
      end
      default: ;
    endcase
  end

  assign bus.alu_ready_o = w_alu_gnt;
  assign bus.lsu_ready_o = w_lsu_gnt;

  assign w_xfer    = w_alu_gnt | w_lsu_gnt;
  assign w_sel_req = w_alu_gnt ? w_alu_req : w_lsu_req;
  assign w_commit  = w_xfer & (w_sel_req.rd != '0);

  // RF write port; address/data hold between commits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      r_wr_en <= w_commit;
      if (w_commit) begin
        r_rd   <= w_sel_req.rd;
        r_data <= w_sel_req.data;
      end
    end
  end

  assign bus.rf_wr_en_o   = r_wr_en;
  assign bus.rf_rd_o      = r_rd;
  assign bus.rf_wr_data_o = r_data;

  wb_scoreboard u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (bus.issue_set_i),
    .set_rd_i (bus.issue_rd_i),
    .clr_i    (w_commit),
    .clr_rd_i (w_sel_req.rd),
    .flush_i  (bus.flush_i),
    .rs1_i    (bus.rs1_i),
    .rs2_i    (bus.rs2_i),
    .hazard_o (bus.hazard_o),
    .busy_o   (bus.busy_o)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Expectations adapt to WB_ARB_ROUND_ROBIN_EN.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] alu_d;
  logic [31:0] lsu_d;
  logic [31:0] exp_d;
  logic [4:0]  exp_rd;
  logic        exp_alu [3];

  initial begin
    bus.alu_valid_i = 0;
    bus.alu_rd_i    = 0;
    bus.alu_data_i  = 0;
    bus.lsu_valid_i = 0;
    bus.lsu_rd_i    = 0;
    bus.lsu_data_i  = 0;
    bus.issue_set_i = 0;
    bus.issue_rd_i  = 0;
    bus.rs1_i       = 0;
    bus.rs2_i       = 0;
    bus.flush_i     = 0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_alu = '{1'b1, 1'b0, 1'b1};
`else
    exp_alu = '{1'b0, 1'b0, 1'b0};
`endif

    // Reset state, ready live during reset
    step();
    step();
    check("rst_wr_en", bus.rf_wr_en_o, 0);
    check("rst_rd", bus.rf_rd_o, 0);
    check("rst_data", bus.rf_wr_data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_hazard", bus.hazard_o, 0);
    bus.alu_valid_i = 1;
    bus.alu_rd_i    = 5'd4;
    settle();
    check("rst_alu_ready", bus.alu_ready_o, 1);
    step();
    check("rst_no_xfer", bus.rf_wr_en_o, 0);
    bus.alu_valid_i = 0;
    rst = 1'b0;

    // ALU only: rd=5 data=0x1234
    bus.alu_valid_i = 1;
    bus.alu_rd_i    = 5'd5;
    bus.alu_data_i  = 32'h1234;
    settle();
    check("alu_ready", bus.alu_ready_o, 1);
    check("alu_lsu_ready", bus.lsu_ready_o, 0);
    step();
    bus.alu_valid_i = 0;
    check("alu_wr_en", bus.rf_wr_en_o, 1);
    check("alu_rd", bus.rf_rd_o, 5);
    check("alu_data", bus.rf_wr_data_o, 32'h1234);
    step();
    check("idle_wr_en", bus.rf_wr_en_o, 0);
    check("idle_rd_hold", bus.rf_rd_o, 5);
    check("idle_data_hold", bus.rf_wr_data_o, 32'h1234);

    // Tie for three cycles from a fresh reset
    do_reset();
    alu_d = 32'hA0;
    lsu_d = 32'hB0;
    bus.alu_valid_i = 1;
    bus.alu_rd_i    = 5'd1;
    bus.lsu_valid_i = 1;
    bus.lsu_rd_i    = 5'd2;
    for (int i = 0; i < 3; i++) begin
      bus.alu_data_i = alu_d;
      bus.lsu_data_i = lsu_d;
      settle();
      check($sformatf("tie%0d_alu_rdy", i),
            bus.alu_ready_o, exp_alu[i]);
      check($sformatf("tie%0d_lsu_rdy", i),
            bus.lsu_ready_o, !exp_alu[i]);
      exp_rd = exp_alu[i] ? 5'd1 : 5'd2;
      exp_d  = exp_alu[i] ? alu_d : lsu_d;
      if (exp_alu[i]) alu_d = alu_d + 1;
      else            lsu_d = lsu_d + 1;
      step();
      check($sformatf("tie%0d_rd", i),
            bus.rf_rd_o, exp_rd);
      check($sformatf("tie%0d_data", i),
            bus.rf_wr_data_o, exp_d);
    end
    bus.alu_valid_i = 0;
    bus.lsu_valid_i = 0;
    step();

    // Scoreboard set, hazard, clear by LSU
    bus.issue_set_i = 1;
    bus.issue_rd_i  = 5'd7;
    step();
    bus.issue_set_i = 0;
    bus.rs1_i = 5'd7;
    settle();
    check("sb_busy7", bus.busy_o, 32'h80);
    check("haz_rs1", bus.hazard_o, 1);
    bus.rs1_i = 5'd0;
    bus.rs2_i = 5'd7;
    settle();
    check("haz_rs2", bus.hazard_o, 1);
    bus.rs2_i = 5'd0;
    settle();
    check("haz_x0", bus.hazard_o, 0);
    bus.rs1_i = 5'd7;
    bus.lsu_valid_i = 1;
    bus.lsu_rd_i    = 5'd7;
    bus.lsu_data_i  = 32'h77;
    settle();
    check("lsu_ready", bus.lsu_ready_o, 1);
    step();
    bus.lsu_valid_i = 0;
    check("lsu_wr_en", bus.rf_wr_en_o, 1);
    check("lsu_rd", bus.rf_rd_o, 7);
    step();
    check("clr_busy", bus.busy_o, 0);
    check("clr_hazard", bus.hazard_o, 0);
    bus.rs1_i = 5'd0;

    // rd=0 write: handshake only
    bus.issue_set_i = 1;
    bus.issue_rd_i  = 5'd9;
    step();
    bus.issue_set_i = 0;
    bus.alu_valid_i = 1;
    bus.alu_rd_i    = 5'd0;
    bus.alu_data_i  = 32'hFFFF_FFFF;
    settle();
    check("x0_ready", bus.alu_ready_o, 1);
    step();
    bus.alu_valid_i = 0;
    check("x0_wr_en", bus.rf_wr_en_o, 0);
    check("x0_busy", bus.busy_o, 32'h200);
    check("x0_data_hold", bus.rf_wr_data_o, 32'h77);

    // Issue of x0 marks nothing
    bus.issue_set_i = 1;
    bus.issue_rd_i  = 5'd0;
    step();
    bus.issue_set_i = 0;
    check("iss_x0", bus.busy_o, 32'h200);

    // Same-edge set and clear of rd=3
    bus.issue_set_i = 1;
    bus.issue_rd_i  = 5'd3;
    bus.alu_valid_i = 1;
    bus.alu_rd_i    = 5'd3;
    bus.alu_data_i  = 32'h33;
    step();
    check("setclr_busy", bus.busy_o, 32'h208);
    check("setclr_wr_en", bus.rf_wr_en_o, 1);

    // Flush beats issue; write path unaffected
    bus.issue_rd_i  = 5'd4;
    bus.flush_i     = 1;
    bus.alu_rd_i    = 5'd10;
    bus.alu_data_i  = 32'hAA;
    step();
    bus.issue_set_i = 0;
    bus.flush_i     = 0;
    bus.alu_valid_i = 0;
    check("flush_busy", bus.busy_o, 0);
    check("flush_wr_en", bus.rf_wr_en_o, 1);
    check("flush_rd", bus.rf_rd_o, 10);
    check("flush_data", bus.rf_wr_data_o, 32'hAA);
    step();

    // Reset the cycle after LSU acceptance
    bus.issue_set_i = 1;
    bus.issue_rd_i  = 5'd12;
    step();
    bus.issue_set_i = 0;
    bus.lsu_valid_i = 1;
    bus.lsu_rd_i    = 5'd12;
    bus.lsu_data_i  = 32'hCAFE;
    step();
    bus.lsu_valid_i = 0;
    check("pre_rst_wr_en", bus.rf_wr_en_o, 1);
    rst = 1'b1;
    settle();
    check("mid_rst_wr_en", bus.rf_wr_en_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_data", bus.rf_wr_data_o, 0);

    // Acceptance while in reset is dropped
    bus.lsu_valid_i = 1;
    settle();
    check("in_rst_lsu_rdy", bus.lsu_ready_o, 1);
    step();
    bus.lsu_valid_i = 0;
    rst = 1'b0;
    step();
    check("post_rst_wr_en", bus.rf_wr_en_o, 0);
    check("post_rst_rd", bus.rf_rd_o, 0);

    // First request after reset commits
    bus.alu_valid_i = 1;
    bus.alu_rd_i    = 5'd2;
    bus.alu_data_i  = 32'h55;
    step();
    bus.alu_valid_i = 0;
    check("post_wr_en", bus.rf_wr_en_o, 1);
    check("post_rd", bus.rf_rd_o, 2);
    check("post_data", bus.rf_wr_data_o, 32'h55);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
